// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder and the datapath extender:
// imm_src codes, instruction field width, and the extender equations used
// for the optional round-trip consistency check.
package imm_encoder_pkg;

    localparam int FIELD_W = 25;   // instr[31:7]

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // Datapath extender: rebuild the sign-extended immediate from a packed field.
    function automatic logic [31:0] imm_extend(input logic [FIELD_W-1:0] f,
                                               input logic [1:0]         src);
        logic [31:0] r;
        r = '0;
        case (src)
            IMM_I:   r = {{20{f[24]}}, f[24:13]};
            IMM_S:   r = {{20{f[24]}}, f[24:18], f[4:0]};
            IMM_B:   r = {{20{f[24]}}, f[0], f[23:18], f[4:1], 1'b0};
            IMM_J:   r = {{12{f[24]}}, f[12:5], f[13], f[23:14], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: 32-bit signed immediate + format -> 25-bit instruction
// field plus a flag for values the format cannot represent. Out-of-range values
// are still packed from their low bits.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [31:0]        imm,
    input  logic [1:0]         imm_src,
    output logic [FIELD_W-1:0] field,
    output logic               err
);

    logic fits_12;   // V[31:11] all equal
    logic fits_13;   // V[31:12] all equal
    logic fits_21;   // V[31:20] all equal

    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

    // Scatter immediate bits into the per-format field positions and flag range errors.
    always_comb begin
        field = '0;
        err   = 1'b0;
        case (imm_src)
            IMM_I: begin
                field[24:13] = imm[11:0];
                err          = ~fits_12;
            end
            IMM_S: begin
                field[24:18] = imm[11:5];
                field[4:0]   = imm[4:0];
                err          = ~fits_12;
            end
            IMM_B: begin
                field[24]    = imm[12];
                field[23:18] = imm[10:5];
                field[4:1]   = imm[4:1];
                field[0]     = imm[11];
                err          = ~fits_13 | imm[0];
            end
            IMM_J: begin
                field[24]    = imm[20];
                field[23:14] = imm[10:1];
                field[13]    = imm[11];
                field[12:5]  = imm[19:12];
                err          = ~fits_21 | imm[0];
            end
            default: begin
                field = '0;
                err   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder top: two-stage valid/ready pipeline around imm_pack.
// S1 holds the raw immediate and format, S2 holds the packed field, format and
// range-error flag. A saturating counter tallies delivered beats with range errors.
// Optional feature macro: IMM_ROUNDTRIP_CHECK_EN adds out_rt_mismatch, which
// re-extends each packed field and flags disagreement with the original value.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_imm,
    input  logic [1:0]         in_imm_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] out_field,
    output logic [1:0]         out_imm_src,
    output logic               out_range_err,
`ifdef IMM_ROUNDTRIP_CHECK_EN
    output logic               out_rt_mismatch,
`endif
    input  logic               clr_err,
    output logic [CNT_W-1:0]   err_count
);

    logic               s1_valid_reg;
    logic [31:0]        s1_imm_reg;
    logic [1:0]         s1_src_reg;

    logic               s2_valid_reg;
    logic [FIELD_W-1:0] s2_field_reg;
    logic [1:0]         s2_src_reg;
    logic               s2_err_reg;

    logic [CNT_W-1:0]   err_count_reg;

    logic               s2_adv;
    logic               s1_adv;
    logic [FIELD_W-1:0] pack_field;
    logic               pack_err;

    // A stage may load when it is empty or its contents leave this cycle.
    assign s2_adv   = ~s2_valid_reg | out_ready;
    assign s1_adv   = ~s1_valid_reg | s2_adv;
    assign in_ready = s1_adv;

    imm_pack u_pack (
        .imm     (s1_imm_reg),
        .imm_src (s1_src_reg),
        .field   (pack_field),
        .err     (pack_err)
    );

    // Stage 1: capture the raw immediate when the stage can advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_imm_reg   <= '0;
            s1_src_reg   <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_imm_reg <= in_imm;
                s1_src_reg <= in_imm_src;
            end
        end
    end

    // Stage 2: register the packed result; held stable while backpressured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_field_reg <= '0;
            s2_src_reg   <= '0;
            s2_err_reg   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_field_reg <= pack_field;
                s2_src_reg   <= s1_src_reg;
                s2_err_reg   <= pack_err;
            end
        end
    end

    // Count delivered error beats; clear has priority and the count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (clr_err) begin
            err_count_reg <= '0;
        end else if (s2_valid_reg && out_ready && s2_err_reg && (err_count_reg != '1)) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic rt_mismatch_reg;
    logic rt_mismatch_next;

    assign rt_mismatch_next = (imm_extend(pack_field, s1_src_reg) != s1_imm_reg) && !pack_err;

    // Round-trip flag travels with the S2 beat it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rt_mismatch_reg <= 1'b0;
        end else if (s2_adv && s1_valid_reg) begin
            rt_mismatch_reg <= rt_mismatch_next;
        end
    end

    assign out_rt_mismatch = rt_mismatch_reg;
`endif

    assign out_valid     = s2_valid_reg;
    assign out_field     = s2_field_reg;
    assign out_imm_src   = s2_src_reg;
    assign out_range_err = s2_err_reg;
    assign err_count     = err_count_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed spec vectors, backpressure, reset and
// counter corner cases, then randomized traffic against an arithmetic model.
module tb_imm_encoder;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [1:0]  in_imm_src;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_field;
    logic [1:0]  out_imm_src;
    logic        out_range_err;
    logic        clr_err;
    logic [CNT_W-1:0] err_count;
`ifdef IMM_ROUNDTRIP_CHECK_EN
    logic        out_rt_mismatch;
`endif

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_imm        (in_imm),
        .in_imm_src    (in_imm_src),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_field     (out_field),
        .out_imm_src   (out_imm_src),
        .out_range_err (out_range_err),
`ifdef IMM_ROUNDTRIP_CHECK_EN
        .out_rt_mismatch (out_rt_mismatch),
`endif
        .clr_err       (clr_err),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] field;
        logic [1:0]  src;
        logic        err;
    } beat_t;

    beat_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    em    = 0;   // expected err_count
    int    nout  = 0;   // delivered beats

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference packer written from the format rules: representable ranges as
    // signed bounds, field positions as shift/mask arithmetic.
    function automatic beat_t model(input logic [31:0] v, input logic [1:0] s);
        beat_t       b;
        int signed   sv;
        logic [31:0] t;
        sv = signed'(v);
        t  = 0;
        b.err = 1'b0;
        case (s)
            2'd0: begin
                t = (v & 32'hFFF) << 13;
                b.err = (sv < -2048) || (sv > 2047);
            end
            2'd1: begin
                t = (((v >> 5) & 32'h7F) << 18) | (v & 32'h1F);
                b.err = (sv < -2048) || (sv > 2047);
            end
            2'd2: begin
                t = (((v >> 12) & 32'h1) << 24) | (((v >> 5) & 32'h3F) << 18)
                  | (((v >> 1) & 32'hF) << 1) | ((v >> 11) & 32'h1);
                b.err = (sv < -4096) || (sv > 4095) || ((v % 2) == 1);
            end
            default: begin
                t = (((v >> 20) & 32'h1) << 24) | (((v >> 1) & 32'h3FF) << 14)
                  | (((v >> 11) & 32'h1) << 13) | (((v >> 12) & 32'hFF) << 5);
                b.err = (sv < -(1 << 20)) || (sv > (1 << 20) - 1) || ((v % 2) == 1);
            end
        endcase
        b.field = t[24:0];
        b.src   = s;
        return b;
    endfunction

    // One clock: check handshake-visible state at the falling edge, update the
    // model for the handshakes about to happen, then step past the rising edge.
    task automatic cyc();
        logic  exp_ir;
        logic  out_hs;
        beat_t e;
        @(negedge clk);
        exp_ir = (q.size() < 2) || out_ready;
        chk("in_ready", in_ready, exp_ir);
        chk("err_count", err_count, em);
        if (q.size() == 0) chk("out_valid_empty", out_valid, 0);
        out_hs = 1'b0;
        e.err  = 1'b0;
        if (out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                out_hs = 1'b1;
                nout++;
                chk("out_field", out_field, e.field);
                chk("out_imm_src", out_imm_src, e.src);
                chk("out_range_err", out_range_err, e.err);
`ifdef IMM_ROUNDTRIP_CHECK_EN
                chk("out_rt_mismatch", out_rt_mismatch, 0);
`endif
                $display("beat %0d: field=%07h src=%0d err=%0b", nout, out_field, out_imm_src, out_range_err);
            end
        end
        if (clr_err) em = 0;
        else if (out_hs && e.err && em < CNT_MAX) em++;
        if (in_valid && exp_ir) q.push_back(model(in_imm, in_imm_src));
        @(posedge clk);
        #1;
    endtask

    // Single beat through an idle pipe with out_ready high; checks latency and values.
    task automatic send_one(input string tag, input logic [31:0] v, input logic [1:0] s,
                            input logic [24:0] ef, input logic ee);
        in_valid = 1'b1; in_imm = v; in_imm_src = s; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        cyc();
        chk({tag, "_lat2"}, out_valid, 1);
        chk({tag, "_field"}, out_field, ef);
        chk({tag, "_err"}, out_range_err, ee);
`ifdef IMM_ROUNDTRIP_CHECK_EN
        chk({tag, "_rt"}, out_rt_mismatch, 0);
`endif
        cyc();
    endtask

    initial begin
        int n0;
        rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_imm_src = '0;
        out_ready = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_field", out_field, 0);
        chk("rst_out_imm_src", out_imm_src, 0);
        chk("rst_out_range_err", out_range_err, 0);
        chk("rst_err_count", err_count, 0);
        rst = 1'b0;
        cyc();

        // Spec vectors
        send_one("I_neg", 32'hFFFFF800, 2'd0, 25'h1000000, 1'b0);
        send_one("I_ovf", 32'h00000800, 2'd0, 25'h1000000, 1'b1);
        chk("I_ovf_count", err_count, 1);
        send_one("S_m1",  32'hFFFFFFFF, 2'd1, 25'h1FC001F, 1'b0);
        send_one("B_max", 32'h00000FFE, 2'd2, 25'h0FC001F, 1'b0);
        send_one("J_odd", 32'h00000001, 2'd3, 25'h0000000, 1'b1);
        send_one("J_big", 32'h000FFFFE, 2'd3, 25'h0FFFFE0, 1'b0);

        // Backpressure: two beats fill the pipe, third stalls, order preserved
        n0 = nout;
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 32'h00000123; in_imm_src = 2'd0; cyc();
        in_imm = 32'hFFFFF000; in_imm_src = 2'd2; cyc();
        in_imm = 32'h00012346; in_imm_src = 2'd3;
        chk("bp_in_ready_full", in_ready, 0);
        cyc();
        chk("bp_in_ready_hold", in_ready, 0);
        chk("bp_out_valid_hold", out_valid, 1);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
        chk("bp_drained", q.size(), 0);
        chk("bp_count", nout - n0, 3);

        // Reset with two beats in flight and a nonzero error count
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 32'h00000800; in_imm_src = 2'd0; cyc();
        in_imm = 32'h00000005; in_imm_src = 2'd3; cyc();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err_count", err_count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete(); em = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc();

        // clr_err coinciding with an error beat handshake
        send_one("pre_clr", 32'h80000000, 2'd1, 25'h0000000, 1'b1);
        chk("pre_clr_count", err_count, 1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 32'h00000800; in_imm_src = 2'd0; cyc();
        in_valid = 1'b0; cyc();
        out_ready = 1'b1; clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("clr_wins", err_count, 0);

        // Saturation of the error counter
        out_ready = 1'b1;
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            in_valid = 1'b1; in_imm = 32'h00012345; in_imm_src = 2'd0; cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("sat_count", err_count, CNT_MAX);

        // Randomized traffic
        clr_err = 1'b1; cyc(); clr_err = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            in_valid   = ($urandom_range(0, 3) != 0);
            in_imm_src = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            case (sel)
                0: in_imm = $urandom;
                1: in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: in_imm = (32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000) & ~32'h1;
                default: in_imm = 32'($urandom_range(0, 16383)) - 32'd8192;
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
            clr_err   = ($urandom_range(0, 99) == 0);
            cyc();
        end
        in_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
        chk("final_drain", q.size(), 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
